// File: rtl/loop_filter_pkg.sv
// loop_filter_pkg: reset defaults, saturation and error-magnitude helpers for the PI loop filter
package loop_filter_pkg;
  localparam int KP_SH_DEF = 4;
  localparam int KI_SH_DEF = 10;
  localparam int LOCK_THR_OFS = 8;
  localparam int LOCK_CNT_DEF = 64;
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  function automatic logic [31:0] abs_err(input logic signed [31:0] e);
    return e[31] ? 32'(-e) : 32'(e);
  endfunction
endpackage

// File: rtl/loop_filter_pi_ch_lock_detector.sv
// lock_detector: counts consecutive accepted samples with |err| <= thr, saturating at lock_cnt; ports clk/rst, i_clear, i_accept, i_err, i_thr, i_lock_cnt, o_locked
module lock_detector
  import loop_filter_pkg::*;
#(
  parameter int ERR_W = 16,
  parameter int LOCK_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_accept,
  input  logic signed [ERR_W-1:0] i_err,
  input  logic [ERR_W-2:0]        i_thr,
  input  logic [LOCK_W-1:0]       i_lock_cnt,
  output logic                    o_locked
);
  logic [LOCK_W-1:0] r_cnt;
  logic              w_in_thr;
  assign w_in_thr = abs_err(32'(i_err)) <= 32'(i_thr);
  assign o_locked = (r_cnt == i_lock_cnt) && (|i_lock_cnt);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_accept) r_cnt <= !w_in_thr ? '0 : r_cnt >= i_lock_cnt ? i_lock_cnt : r_cnt + 1'b1;
endmodule

// File: rtl/loop_filter_pi_ch.sv
// loop_filter_pi_ch: two-stage PI loop filter with saturation, anti-windup, cfg handshake (cfg_valid/cfg_ready), hold/ena/acc_clear controls and lock detect; phase_err in, ctrl/ctrl_valid/sat_hi/sat_lo/locked out
module loop_filter_pi_ch
  import loop_filter_pkg::*;
#(
  parameter int ERR_W = 16,
  parameter int CTRL_W = 24,
  parameter int ACC_GUARD = 6,
  parameter int SH_W = 5,
  parameter int LOCK_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     hold,
  input  logic                     acc_clear,
  input  logic                     phase_valid,
  input  logic signed [ERR_W-1:0]  phase_err,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [SH_W-1:0]          cfg_kp_sh,
  input  logic [SH_W-1:0]          cfg_ki_sh,
  input  logic [ERR_W-2:0]         cfg_lock_thr,
  input  logic [LOCK_W-1:0]        cfg_lock_cnt,
  output logic signed [CTRL_W-1:0] ctrl,
  output logic                     ctrl_valid,
  output logic                     sat_hi,
  output logic                     sat_lo,
  output logic                     locked
);
  localparam int ACC_W = CTRL_W + ACC_GUARD;
  localparam logic [ERR_W-2:0] LOCK_THR_RST = (ERR_W-1)'(1) << (ERR_W - LOCK_THR_OFS);
  logic [SH_W-1:0]          r_kp_sh, r_ki_sh;
  logic [ERR_W-2:0]         r_lock_thr;
  logic [LOCK_W-1:0]        r_lock_cnt;
  logic signed [ACC_W-1:0]  r_p_q, r_i_q;
  logic                     r_s1_valid, r_ctrl_valid, r_sat_hi, r_sat_lo;
  logic signed [CTRL_W-1:0] r_i_acc, r_ctrl;
  logic                     w_accept, w_windup;
  logic signed [ACC_W-1:0]  w_err_ext, w_sum, w_int;
  logic signed [63:0]       w_sum64, w_sum_sat64;
  logic signed [CTRL_W-1:0] w_int_sat;
  assign w_accept = ena && phase_valid && !hold && !acc_clear;
  assign w_err_ext = ACC_W'(phase_err);
  assign w_sum = ACC_W'(r_i_acc) + r_p_q;
  assign w_int = ACC_W'(r_i_acc) + r_i_q;
  assign w_sum64 = 64'(w_sum);
  assign w_sum_sat64 = sat_to_width(w_sum64, CTRL_W);
  assign w_int_sat = CTRL_W'(sat_to_width(64'(w_int), CTRL_W));
  // integrator frozen while pushing further into the rail the last output clipped against
  assign w_windup = (r_sat_hi && !r_i_q[ACC_W-1] && (|r_i_q)) || (r_sat_lo && r_i_q[ACC_W-1]);
  assign cfg_ready = !r_s1_valid;
  assign ctrl = r_ctrl;
  assign ctrl_valid = r_ctrl_valid;
  assign sat_hi = r_sat_hi;
  assign sat_lo = r_sat_lo;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_kp_sh <= SH_W'(KP_SH_DEF);
      r_ki_sh <= SH_W'(KI_SH_DEF);
      r_lock_thr <= LOCK_THR_RST;
      r_lock_cnt <= LOCK_W'(LOCK_CNT_DEF);
      r_p_q <= '0;
      r_i_q <= '0;
      r_s1_valid <= 1'b0;
      r_ctrl_valid <= 1'b0;
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b0;
      r_i_acc <= '0;
      r_ctrl <= '0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        r_kp_sh <= cfg_kp_sh;
        r_ki_sh <= cfg_ki_sh;
        r_lock_thr <= cfg_lock_thr;
        r_lock_cnt <= cfg_lock_cnt;
      end
      if (acc_clear) begin
        r_s1_valid <= 1'b0;
        r_ctrl_valid <= 1'b0;
        r_sat_hi <= 1'b0;
        r_sat_lo <= 1'b0;
        r_i_acc <= '0;
        r_ctrl <= '0;
      end else begin
        r_s1_valid <= w_accept;
        r_ctrl_valid <= r_s1_valid;
        if (w_accept) begin
          r_p_q <= w_err_ext >>> r_kp_sh;
          r_i_q <= w_err_ext >>> r_ki_sh;
        end
        if (r_s1_valid) begin
          r_ctrl <= CTRL_W'(w_sum_sat64);
          r_sat_hi <= w_sum64 > w_sum_sat64;
          r_sat_lo <= w_sum64 < w_sum_sat64;
          if (!w_windup) r_i_acc <= w_int_sat;
        end
      end
    end
  lock_detector #(.ERR_W(ERR_W), .LOCK_W(LOCK_W)) u_lock (
    .clk(clk),
    .rst(rst),
    .i_clear(acc_clear),
    .i_accept(w_accept),
    .i_err(phase_err),
    .i_thr(r_lock_thr),
    .i_lock_cnt(r_lock_cnt),
    .o_locked(locked)
  );
endmodule

// File: tb/tb_loop_filter_pi_ch.sv
// tb_loop_filter_pi_ch: directed vectors with hand-computed expectations for loop_filter_pi_ch
module tb_loop_filter_pi_ch;
  logic clk = 1'b0;
  logic rst, ena, hold, acc_clear, phase_valid, cfg_valid;
  logic signed [15:0] phase_err;
  logic cfg_ready, ctrl_valid, sat_hi, sat_lo, locked;
  logic [4:0] cfg_kp_sh, cfg_ki_sh;
  logic [14:0] cfg_lock_thr;
  logic [7:0] cfg_lock_cnt;
  logic signed [23:0] ctrl;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  loop_filter_pi_ch dut (
    .clk(clk), .rst(rst), .ena(ena), .hold(hold), .acc_clear(acc_clear),
    .phase_valid(phase_valid), .phase_err(phase_err),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_kp_sh(cfg_kp_sh), .cfg_ki_sh(cfg_ki_sh),
    .cfg_lock_thr(cfg_lock_thr), .cfg_lock_cnt(cfg_lock_cnt),
    .ctrl(ctrl), .ctrl_valid(ctrl_valid), .sat_hi(sat_hi), .sat_lo(sat_lo), .locked(locked)
  );
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_cfg(input int kp, input int ki, input int thr, input int cnt);
    cfg_valid = 1'b1;
    cfg_kp_sh = 5'(kp);
    cfg_ki_sh = 5'(ki);
    cfg_lock_thr = 15'(thr);
    cfg_lock_cnt = 8'(cnt);
    step;
    cfg_valid = 1'b0;
  endtask
  task automatic clear;
    acc_clear = 1'b1;
    step;
    acc_clear = 1'b0;
  endtask
  task automatic lock_smp(input string tag, input int err, input int exp);
    phase_err = 16'(err);
    step;
    chk(tag, locked, exp);
  endtask
  initial begin
    rst = 1'b1; ena = 1'b0; hold = 1'b0; acc_clear = 1'b0; phase_valid = 1'b0; phase_err = '0;
    cfg_valid = 1'b0; cfg_kp_sh = '0; cfg_ki_sh = '0; cfg_lock_thr = '0; cfg_lock_cnt = '0;
    step;
    step;
    chk("rst_ctrl", ctrl, 0);
    chk("rst_valid", ctrl_valid, 0);
    chk("rst_sat", {sat_hi, sat_lo}, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ready", cfg_ready, 1);
    rst = 1'b0;
    ena = 1'b1;
    phase_valid = 1'b1; phase_err = 16'sd1024;
    step;
    chk("pi_lat_valid", ctrl_valid, 0);
    chk("pi_ready_low", cfg_ready, 0);
    step;
    chk("pi_ctrl1", ctrl, 64);
    chk("pi_valid1", ctrl_valid, 1);
    phase_err = 16'sd0;
    step;
    chk("pi_ctrl2", ctrl, 65);
    phase_valid = 1'b0;
    step;
    chk("pi_iacc", ctrl, 2);
    step;
    chk("pi_valid_end", ctrl_valid, 0);
    clear;
    chk("clr_ctrl", ctrl, 0);
    set_cfg(0, 0, 256, 64);
    phase_valid = 1'b1; phase_err = 16'sd32767;
    for (int i = 0; i < 260; i++) begin
      step;
      if (i == 256) begin
        chk("sat_s256_ctrl", ctrl, 8388352);
        chk("sat_s256_hi", sat_hi, 0);
      end
      if (i == 257) begin
        chk("sat_s257_ctrl", ctrl, 8388607);
        chk("sat_s257_hi", sat_hi, 1);
      end
    end
    phase_err = -16'sd32768;
    step;
    chk("sat_s260_ctrl", ctrl, 8388607);
    phase_valid = 1'b0;
    step;
    chk("windup_ctrl", ctrl, 8355839);
    chk("windup_hi", sat_hi, 0);
    clear;
    phase_valid = 1'b1; phase_err = -16'sd32768;
    for (int i = 0; i < 258; i++) begin
      step;
      if (i == 256) begin
        chk("neg_s256_ctrl", ctrl, -8388608);
        chk("neg_s256_lo", sat_lo, 0);
      end
      if (i == 257) begin
        chk("neg_s257_ctrl", ctrl, -8388608);
        chk("neg_s257_lo", sat_lo, 1);
      end
    end
    phase_valid = 1'b0;
    step;
    step;
    clear;
    phase_valid = 1'b1; phase_err = 16'sd16;
    step;
    chk("cfg_ready_stream", cfg_ready, 0);
    cfg_valid = 1'b1; cfg_kp_sh = 5'd2; cfg_ki_sh = 5'd3; cfg_lock_thr = 15'd256; cfg_lock_cnt = 8'd64;
    step;
    chk("cfg_ready_b2b", cfg_ready, 0);
    chk("cfg_ctrl_a", ctrl, 16);
    phase_valid = 1'b0;
    step;
    chk("cfg_ready_idle", cfg_ready, 1);
    chk("cfg_ctrl_b", ctrl, 32);
    phase_valid = 1'b1;
    step;
    cfg_valid = 1'b0;
    step;
    chk("cfg_old_shift", ctrl, 48);
    phase_valid = 1'b0;
    step;
    chk("cfg_new_shift", ctrl, 52);
    phase_valid = 1'b1; phase_err = 16'sd0;
    step;
    phase_valid = 1'b0;
    step;
    chk("cfg_new_ki", ctrl, 50);
    clear;
    set_cfg(4, 10, 100, 3);
    phase_valid = 1'b1;
    lock_smp("lock_a", 50, 0);
    lock_smp("lock_b", -80, 0);
    lock_smp("lock_thr_eq", 100, 1);
    lock_smp("lock_hold", 50, 1);
    lock_smp("lock_thr_over", 101, 0);
    lock_smp("lock_c", 50, 0);
    lock_smp("lock_d", 50, 0);
    lock_smp("lock_minneg", -32768, 0);
    lock_smp("lock_e", 50, 0);
    lock_smp("lock_f", 50, 0);
    lock_smp("lock_g", 50, 1);
    phase_valid = 1'b0;
    step;
    step;
    clear;
    chk("clr_locked", locked, 0);
    chk("clr_ctrl2", ctrl, 0);
    phase_valid = 1'b1; phase_err = 16'sd1024;
    step;
    phase_valid = 1'b0;
    step;
    chk("hold_pre", ctrl, 64);
    hold = 1'b1; phase_valid = 1'b1; phase_err = 16'sd1000;
    step;
    chk("hold_ready", cfg_ready, 1);
    step;
    chk("hold_valid", ctrl_valid, 0);
    chk("hold_ctrl", ctrl, 64);
    hold = 1'b0; phase_err = 16'sd1024;
    step;
    hold = 1'b1;
    step;
    chk("hold_inflight_valid", ctrl_valid, 1);
    chk("hold_inflight_ctrl", ctrl, 65);
    hold = 1'b0;
    step;
    phase_valid = 1'b0; acc_clear = 1'b1;
    step;
    acc_clear = 1'b0;
    chk("clr_inflight_ctrl", ctrl, 0);
    chk("clr_inflight_valid", ctrl_valid, 0);
    step;
    chk("clr_discard", ctrl_valid, 0);
    phase_valid = 1'b1;
    step;
    phase_valid = 1'b0;
    step;
    chk("clr_cfg_kept", ctrl, 64);
    ena = 1'b0; phase_valid = 1'b1;
    step;
    chk("ena_ready", cfg_ready, 1);
    step;
    chk("ena_valid", ctrl_valid, 0);
    chk("ena_ctrl", ctrl, 64);
    ena = 1'b1;
    step;
    ena = 1'b0;
    step;
    chk("ena_inflight_valid", ctrl_valid, 1);
    chk("ena_inflight_ctrl", ctrl, 65);
    ena = 1'b1; phase_valid = 1'b0;
    step;
    set_cfg(0, 0, 256, 64);
    phase_valid = 1'b1;
    step;
    step;
    #2 rst = 1'b1;
    #1;
    chk("arst_ctrl", ctrl, 0);
    chk("arst_valid", ctrl_valid, 0);
    chk("arst_ready", cfg_ready, 1);
    phase_valid = 1'b0;
    step;
    rst = 1'b0;
    phase_valid = 1'b1; phase_err = 16'sd1024;
    step;
    phase_err = 16'sd0;
    step;
    chk("arst_kp_def", ctrl, 64);
    phase_valid = 1'b0;
    step;
    chk("arst_ki_def", ctrl, 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
